register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register and data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning address width, giving 2**ADDR_W registers (16).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all writes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port RS1, input, ADDR_W bits: read address, port 1.
REQ-006 The block SHALL have port RS2, input, ADDR_W bits: read address, port 2.
REQ-007 The block SHALL have port RS3, input, ADDR_W bits: read address, port 3.
REQ-008 The block SHALL have port RD, input, ADDR_W bits: write (destination) address.
REQ-009 The block SHALL have port WD, input, DATA_W bits: write data.
REQ-010 The block SHALL have port wr_enable, input, 1 bit: write enable, active high.
REQ-011 The block SHALL have port RD1, output, DATA_W bits: read data for RS1.
REQ-012 The block SHALL have port RD2, output, DATA_W bits: read data for RS2.
REQ-013 The block SHALL have port RD3, output, DATA_W bits: read data for RS3.
REQ-014 The port order SHALL be RS1, RS2, RS3, RD, WD, wr_enable, clk, rst, RD1, RD2, RD3, so positional instantiation works.

Function
REQ-015 The storage SHALL be 16 x DATA_W general registers, all writable; no register is hardwired.
REQ-016 On a rising clk edge with rst high and wr_enable=1, register[RD] SHALL take the value WD.
REQ-017 With wr_enable=0, no register SHALL change, whatever the values of RD and WD.
REQ-018 Reads SHALL be combinational (zero latency): RDn = register[RSn] as currently stored.
REQ-019 The three read ports SHALL be independent; any or all of them may address the same register, and each SHALL return the identical value.
REQ-020 Read and write to the same address in the same cycle: the read SHALL return the old value until the edge, then the new value immediately after it (no bypass).
REQ-021 X or Z on WD with wr_enable=0 SHALL NOT corrupt any register.

Reset
REQ-022 While rst=0, all 16 registers SHALL be cleared to 0 immediately, independent of clk.
REQ-023 While rst=0, RD1, RD2 and RD3 SHALL read 0 for every address.
REQ-024 Writes SHALL be blocked while rst=0; a write edge coinciding with reset assertion SHALL lose to reset.
REQ-025 After rst deasserts, the first write SHALL take effect on the first rising edge at which wr_enable=1.

Structure
REQ-026 A shared package rf_pkg SHALL hold DATA_W, ADDR_W, NUM_REGS=16 and typedefs for the address (logic [ADDR_W-1:0]) and data (logic [DATA_W-1:0]) types.
REQ-027 The design SHALL use a single flat module: a register array, a write-decode process and three read multiplexers.
REQ-028 The design SHALL NOT use sub-modules, except an optional rf_read_port mux instantiated three times.

Verification
REQ-029 Reset check: hold rst=0 for 20 time units, then sweep RS1, RS2 and RS3 over 0..15 -> RD1, RD2 and RD3 all read 0.
REQ-030 Basic write: rst=1, wr_enable=1, RD=3, WD=99, one clock edge, then RS1=3 -> RD1=99.
REQ-031 Write disabled: wr_enable=0, RD=4, WD=50, one clock edge, then RS1=4 -> RD1=0 and register 3 still reads 99.
REQ-032 Multi-port read: write 255 to register 5, then set RS1=3, RS2=5, RS3=5 -> RD1=99, RD2=255, RD3=255.
REQ-033 Overwrite and same-cycle read: RS1=3 and write WD=2 to RD=3 -> RD1 reads 99 before the edge and 2 after it.
REQ-034 Mid-operation reset: pulse rst=0 between clock edges -> all outputs read 0 immediately and stay 0 after rst returns high.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared widths and types for the 16-entry register file.
// Latency: n/a (definitions only).
// Backpressure: n/a (no flow control in this block).
package rf_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 4;
   localparam int NUM_REGS = 16;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

endpackage : rf_pkg

// File: rtl/register_file_if.sv
// Bundle of register-file address/data signals: three read ports plus one write port.
// Latency: reads combinational, write lands on the next rising clk edge.
// Backpressure: none; the file accepts a write every cycle.
//
// Ports (signals): rs1/rs2/rs3 read addresses, rd/wd/wr_enable write side,
// rd1/rd2/rd3 read data. master drives addresses/write data, slave returns read data.
interface rf_if
   import rf_pkg::*;
#(
   parameter int DATA_W = rf_pkg::DATA_W,
   parameter int ADDR_W = rf_pkg::ADDR_W
);

   logic [ADDR_W-1:0] rs1;
   logic [ADDR_W-1:0] rs2;
   logic [ADDR_W-1:0] rs3;
   logic [ADDR_W-1:0] rd;
   logic [DATA_W-1:0] wd;
   logic              wr_enable;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic [DATA_W-1:0] rd3;

   modport master (
      output rs1, rs2, rs3, rd, wd, wr_enable,
      input  rd1, rd2, rd3
   );

   modport slave (
      input  rs1, rs2, rs3, rd, wd, wr_enable,
      output rd1, rd2, rd3
   );

endinterface : rf_if

// File: rtl/register_file_read_port.sv
// One combinational read mux selecting a register out of the packed storage array.
// Latency: zero cycles (pure combinational).
// Backpressure: none.
//
// Ports: regs (all registers, packed), addr (register index), data (selected register).
module rf_read_port
   import rf_pkg::*;
#(
   parameter int DATA_W   = rf_pkg::DATA_W,
   parameter int ADDR_W   = rf_pkg::ADDR_W,
   parameter int NUM_REGS = 2**ADDR_W
) (
   input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
   input  logic [ADDR_W-1:0]               addr,
   output logic [DATA_W-1:0]               data
);

   assign data = regs[addr];

endmodule : rf_read_port

// File: rtl/register_file.sv
// 16 x DATA_W register file, three combinational read ports, one clocked write port.
// Latency: reads zero cycles; write visible immediately after the rising clk edge (no bypass).
// Backpressure: none; a write may be issued every cycle.
//
// Ports: RS1/RS2/RS3 read addresses -> RD1/RD2/RD3 read data; RD/WD/wr_enable write;
// clk write clock; rst asynchronous active-low reset that clears every register.
module register_file
   import rf_pkg::*;
#(
   parameter int DATA_W = rf_pkg::DATA_W,
   parameter int ADDR_W = rf_pkg::ADDR_W
) (
   input  logic [ADDR_W-1:0] RS1,
   input  logic [ADDR_W-1:0] RS2,
   input  logic [ADDR_W-1:0] RS3,
   input  logic [ADDR_W-1:0] RD,
   input  logic [DATA_W-1:0] WD,
   input  logic              wr_enable,
   input  logic              clk,
   input  logic              rst,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2,
   output logic [DATA_W-1:0] RD3
);

   localparam int NREGS = 2**ADDR_W;

   logic [NREGS-1:0][DATA_W-1:0] regs_q;
   logic [NREGS-1:0][DATA_W-1:0] regs_d;

   // Write decode: WD only reaches the next-state when enabled, so an
   // undriven WD with wr_enable low cannot leak into storage.
   always_comb begin
      regs_d = regs_q;
      if (wr_enable) begin
         regs_d[RD] = WD;
      end
   end

   // Reset is asynchronous and dominates any coincident write edge; while
   // held low the array stays at zero, which also forces every read to zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         regs_q <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   // Reads come straight from the stored array: a same-address write is only
   // seen after the edge that commits it.
   rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NREGS)) u_rp1 (
      .regs (regs_q),
      .addr (RS1),
      .data (RD1)
   );

   rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NREGS)) u_rp2 (
      .regs (regs_q),
      .addr (RS2),
      .data (RD2)
   );

   rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NREGS)) u_rp3 (
      .regs (regs_q),
      .addr (RS3),
      .data (RD3)
   );

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: reset sweep, table of write/read vectors,
// and hand-written sequences for same-cycle read/write, X on WD, and reset corners.
module tb_register_file;
   import rf_pkg::*;

   logic clk;
   logic rst;

   rf_if #(.DATA_W(32), .ADDR_W(4)) bus ();

   register_file #(.DATA_W(32), .ADDR_W(4)) dut (
      .RS1       (bus.rs1),
      .RS2       (bus.rs2),
      .RS3       (bus.rs3),
      .RD        (bus.rd),
      .WD        (bus.wd),
      .wr_enable (bus.wr_enable),
      .clk       (clk),
      .rst       (rst),
      .RD1       (bus.rd1),
      .RD2       (bus.rd2),
      .RD3       (bus.rd3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] e1;
      logic [31:0] e2;
      logic [31:0] e3;
      string       tag;
   } exp_t;

   exp_t sb_q[$];

   typedef struct {
      bit          we;
      logic [3:0]  rd;
      logic [31:0] wd;
      logic [3:0]  rs1;
      logic [3:0]  rs2;
      logic [3:0]  rs3;
      logic [31:0] e1;
      logic [31:0] e2;
      logic [31:0] e3;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input string tag, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
      exp_t e;
      e.e1 = e1; e.e2 = e2; e.e3 = e3; e.tag = tag;
      sb_q.push_back(e);
   endtask

   task automatic pop_cmp();
      exp_t e;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty: got 0 entries, expected at least 1");
      end else begin
         e = sb_q.pop_front();
         chk({e.tag, ".RD1"}, bus.rd1, e.e1);
         chk({e.tag, ".RD2"}, bus.rd2, e.e2);
         chk({e.tag, ".RD3"}, bus.rd3, e.e3);
      end
   endtask

   task automatic set_rs(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3);
      bus.rs1 = a1;
      bus.rs2 = a2;
      bus.rs3 = a3;
   endtask

   // Watchdog: the run is short; anything this long means the bench is stuck.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{we:1'b1, rd:4'd3,  wd:32'd99,         rs1:4'd3,  rs2:4'd0, rs3:4'd0,
                  e1:32'd99,         e2:32'd0,          e3:32'd0};
      vecs[1] = '{we:1'b0, rd:4'd4,  wd:32'd50,         rs1:4'd4,  rs2:4'd3, rs3:4'd4,
                  e1:32'd0,          e2:32'd99,         e3:32'd0};
      vecs[2] = '{we:1'b1, rd:4'd5,  wd:32'd255,        rs1:4'd3,  rs2:4'd5, rs3:4'd5,
                  e1:32'd99,         e2:32'd255,        e3:32'd255};
      vecs[3] = '{we:1'b1, rd:4'd15, wd:32'hDEADBEEF,   rs1:4'd15, rs2:4'd0, rs3:4'd15,
                  e1:32'hDEADBEEF,   e2:32'd0,          e3:32'hDEADBEEF};
      vecs[4] = '{we:1'b1, rd:4'd0,  wd:32'h12345678,   rs1:4'd0,  rs2:4'd0, rs3:4'd0,
                  e1:32'h12345678,   e2:32'h12345678,   e3:32'h12345678};

      bus.wr_enable = 1'b0;
      bus.rd = '0;
      bus.wd = '0;
      set_rs(4'd0, 4'd0, 4'd0);
      rst = 1'b1;
      #1 rst = 1'b0;

      // Reset state: every address on every port reads zero.
      #20;
      for (int a = 0; a < 16; a++) begin
         set_rs(4'(a), 4'(15 - a), 4'(a));
         push_exp($sformatf("reset_sweep[%0d]", a), 32'd0, 32'd0, 32'd0);
         #1 pop_cmp();
      end

      @(negedge clk) rst = 1'b1;

      // Table of single-cycle write-then-read vectors.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.wr_enable = vecs[i].we;
         bus.rd = vecs[i].rd;
         bus.wd = vecs[i].wd;
         set_rs(vecs[i].rs1, vecs[i].rs2, vecs[i].rs3);
         push_exp($sformatf("vec[%0d]", i), vecs[i].e1, vecs[i].e2, vecs[i].e3);
         @(posedge clk);
         #1 pop_cmp();
      end

      // Same-cycle read/write of register 3: old value before the edge, new after.
      @(negedge clk);
      bus.wr_enable = 1'b1;
      bus.rd = 4'd3;
      bus.wd = 32'd2;
      set_rs(4'd3, 4'd3, 4'd5);
      push_exp("same_cycle_before", 32'd99, 32'd99, 32'd255);
      #1 pop_cmp();
      push_exp("same_cycle_after", 32'd2, 32'd2, 32'd255);
      @(posedge clk);
      #1 pop_cmp();

      // Unknown write data with writes disabled must not disturb storage.
      @(negedge clk);
      bus.wr_enable = 1'b0;
      bus.rd = 4'd5;
      bus.wd = 'x;
      set_rs(4'd5, 4'd0, 4'd3);
      push_exp("x_wd_disabled", 32'd255, 32'h12345678, 32'd2);
      @(posedge clk);
      #1 pop_cmp();

      // Reset pulse between edges: zero immediately, still zero after release.
      @(negedge clk);
      bus.wd = '0;
      set_rs(4'd3, 4'd5, 4'd15);
      #2 rst = 1'b0;
      push_exp("mid_reset_held", 32'd0, 32'd0, 32'd0);
      #1 pop_cmp();
      #1 rst = 1'b1;
      push_exp("mid_reset_released", 32'd0, 32'd0, 32'd0);
      #1 pop_cmp();
      set_rs(4'd0, 4'd5, 4'd15);
      push_exp("mid_reset_next_edge", 32'd0, 32'd0, 32'd0);
      @(posedge clk);
      #1 pop_cmp();

      // Write edge coinciding with reset assertion: reset wins.
      @(negedge clk);
      bus.wr_enable = 1'b1;
      bus.rd = 4'd7;
      bus.wd = 32'd77;
      set_rs(4'd7, 4'd7, 4'd7);
      @(posedge clk);
      rst = 1'b0;
      push_exp("reset_vs_write", 32'd0, 32'd0, 32'd0);
      #1 pop_cmp();

      // First write after reset release lands on the first enabled edge.
      @(negedge clk);
      rst = 1'b1;
      bus.wr_enable = 1'b1;
      bus.rd = 4'd9;
      bus.wd = 32'd9;
      set_rs(4'd9, 4'd7, 4'd9);
      push_exp("post_reset_before", 32'd0, 32'd0, 32'd0);
      #1 pop_cmp();
      push_exp("post_reset_first_write", 32'd9, 32'd0, 32'd9);
      @(posedge clk);
      #1 pop_cmp();
      @(negedge clk) bus.wr_enable = 1'b0;

      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_register_file
